// File: rtl/cost_table_ctrl.sv
// cost_table_ctrl: loads a 64-entry (8 workers x 8 jobs) cost table from a streaming
// loader, serves zero-latency reads to an assignment engine, and captures its result.
//
// Ports:
//   CLK, RST              clock, synchronous active-low reset
//   in_valid/in_data      loader word stream, row-major (worker 0 jobs 0..7, worker 1, ...)
//   in_ready              word accepted this cycle when in_valid is also high
//   W, J, Cost            engine lookup: Cost = mem[{W,J}] while running, else 0
//   jam_rst               hold-reset to the engine, low only while running
//   jam_valid             engine search finished; jam_mincost/jam_matchcount are captured
//   res_valid             one-cycle strobe with res_mincost/res_matchcount
//   table_sum             sum of all entries of the most recent load
//   busy                  high while loading or running
module cost_table_ctrl #(
  parameter int unsigned COST_W = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic [COST_W-1:0]   in_data,
  output logic                in_ready,
  input  logic [2:0]          W,
  input  logic [2:0]          J,
  output logic [COST_W-1:0]   Cost,
  output logic                jam_rst,
  input  logic                jam_valid,
  input  logic [9:0]          jam_mincost,
  input  logic [3:0]          jam_matchcount,
  output logic                res_valid,
  output logic [9:0]          res_mincost,
  output logic [3:0]          res_matchcount,
  output logic [COST_W+5:0]   table_sum,
  output logic                busy
);

  localparam int unsigned SumW = COST_W + 6;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [5:0]        widx_q;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [9:0]        mincost_q;
  logic [3:0]        matchcount_q;
  logic [COST_W-1:0] mem_q [64];
  logic              accept;

  assign in_ready = (state_q == StIdle) || (state_q == StLoad);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad:  if (accept && (widx_q == 6'd63)) state_d = StRun;
      StRun:   if (jam_valid) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The first word of a load replaces the old sum rather than adding to it.
  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = ((state_q == StIdle) ? '0 : sum_q) + {6'd0, in_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= StIdle;
      widx_q       <= 6'd0;
      sum_q        <= '0;
      mincost_q    <= 10'h3FF;
      matchcount_q <= 4'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      // 6-bit index wraps to 0 on the 64th acceptance.
      if (accept) widx_q <= widx_q + 6'd1;
      if ((state_q == StRun) && jam_valid) begin
        mincost_q    <= jam_mincost;
        matchcount_q <= jam_matchcount;
      end
    end
  end

  // Table storage is deliberately not reset; a new load overwrites every entry.
  always_ff @(posedge CLK) begin
    if (RST && accept) mem_q[widx_q] <= in_data;
  end

  assign Cost           = (state_q == StRun) ? mem_q[{W, J}] : '0;
  assign jam_rst        = (state_q != StRun);
  assign res_valid      = (state_q == StDone);
  assign res_mincost    = mincost_q;
  assign res_matchcount = matchcount_q;
  assign table_sum      = sum_q;
  assign busy           = (state_q == StLoad) || (state_q == StRun);

endmodule

// File: tb/tb_cost_table_ctrl.sv
// Directed bench for cost_table_ctrl with scoreboard queues for table sums and results.
module tb_cost_table_ctrl;

  localparam int unsigned COST_W = 7;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic [COST_W-1:0] in_data;
  logic              in_ready;
  logic [2:0]        W, J;
  logic [COST_W-1:0] Cost;
  logic              jam_rst;
  logic              jam_valid;
  logic [9:0]        jam_mincost;
  logic [3:0]        jam_matchcount;
  logic              res_valid;
  logic [9:0]        res_mincost;
  logic [3:0]        res_matchcount;
  logic [COST_W+5:0] table_sum;
  logic              busy;

  cost_table_ctrl #(.COST_W(COST_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .W              (W),
    .J              (J),
    .Cost           (Cost),
    .jam_rst        (jam_rst),
    .jam_valid      (jam_valid),
    .jam_mincost    (jam_mincost),
    .jam_matchcount (jam_matchcount),
    .res_valid      (res_valid),
    .res_mincost    (res_mincost),
    .res_matchcount (res_matchcount),
    .table_sum      (table_sum),
    .busy           (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] mc;
    logic [3:0] cnt;
  } res_t;

  int                checks = 0;
  int                errors = 0;
  logic [COST_W-1:0] tbl     [64];
  logic [COST_W-1:0] exp_mem [64];
  logic [12:0]       sum_sb  [$];
  res_t              res_sb  [$];
  logic [9:0]        last_mc;
  logic [3:0]        last_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Streams n words of tbl; optional stall drops in_valid every third cycle.
  task automatic load_words(input int n, input bit stall, input bit full);
    int acc = 0;
    int cyc = 0;
    logic [12:0] s = '0;
    if (full) begin
      for (int i = 0; i < 64; i++) s += {6'd0, tbl[i]};
      sum_sb.push_back(s);
    end
    while (acc < n && cyc < 500) begin
      in_valid = !(stall && (cyc % 3 == 2));
      in_data  = tbl[acc];
      if (in_valid && (acc == 0 || acc == 63)) chk("in_ready_load", in_ready, 1);
      tick();
      if (in_valid) begin
        exp_mem[acc] = tbl[acc];
        acc++;
        if (acc == 1) chk("busy_after_first", busy, 1);
        if (full && acc == 63) chk("jam_rst_before_last", jam_rst, 1);
        if (full && acc == 64) begin
          chk("jam_rst_run_entry", jam_rst, 0);
          chk("in_ready_run_entry", in_ready, 0);
          chk("busy_run", busy, 1);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", acc, n);
    if (full) chk("table_sum", table_sum, sum_sb.pop_front());
  endtask

  task automatic read_back();
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        W = 3'(w);
        J = 3'(j);
        #1;
        if (Cost !== exp_mem[w*8+j]) chk("cost_readback", Cost, exp_mem[w*8+j]);
      end
    end
    W = 3'd7;
    J = 3'd7;
    #1;
    chk("cost_last_entry", Cost, exp_mem[63]);
  endtask

  task automatic run_engine(input logic [9:0] mc, input logic [3:0] cnt);
    res_t r;
    r.mc  = mc;
    r.cnt = cnt;
    res_sb.push_back(r);
    jam_mincost    = mc;
    jam_matchcount = cnt;
    chk("res_valid_pre", res_valid, 0);
    jam_valid = 1'b1;
    tick();
    jam_valid = 1'b0;
    chk("res_valid_done", res_valid, 1);
    r = res_sb.pop_front();
    chk("res_mincost", res_mincost, r.mc);
    chk("res_matchcount", res_matchcount, r.cnt);
    chk("jam_rst_done", jam_rst, 1);
    chk("in_ready_done", in_ready, 0);
    chk("busy_done", busy, 0);
    chk("cost_done", Cost, 0);
    in_valid = 1'b0;
    tick();
    chk("res_valid_idle", res_valid, 0);
    chk("in_ready_idle", in_ready, 1);
    chk("res_mincost_hold", res_mincost, r.mc);
    chk("res_matchcount_hold", res_matchcount, r.cnt);
    last_mc  = r.mc;
    last_cnt = r.cnt;
  endtask

  initial begin
    RST            = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    W              = '0;
    J              = '0;
    jam_valid      = 1'b0;
    jam_mincost    = '0;
    jam_matchcount = '0;
    tick();
    tick();
    RST = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_jam_rst", jam_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cost", Cost, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_mincost", res_mincost, 10'h3FF);
    chk("rst_res_matchcount", res_matchcount, 0);
    chk("rst_table_sum", table_sum, 0);

    // jam_valid in IDLE must be ignored.
    jam_mincost    = 10'd5;
    jam_matchcount = 4'd7;
    jam_valid      = 1'b1;
    tick();
    jam_valid = 1'b0;
    tick();
    chk("idle_jam_res_valid", res_valid, 0);
    chk("idle_jam_mincost", res_mincost, 10'h3FF);
    chk("idle_jam_busy", busy, 0);

    // Table A: value = index, with stalls.
    for (int i = 0; i < 64; i++) tbl[i] = 7'(i % 128);
    load_words(64, 1'b1, 1'b1);
    chk("sum_2016", table_sum, 2016);
    W = 3'd5;
    J = 3'd3;
    #1;
    chk("cost_w5_j3", Cost, 43);
    read_back();

    // in_valid held through RUN and DONE must not write.
    in_valid = 1'b1;
    in_data  = 7'h55;
    tick();
    tick();
    chk("run_in_ready", in_ready, 0);
    chk("run_sum_hold", table_sum, 2016);
    W = 3'd0;
    J = 3'd0;
    #1;
    chk("run_no_write", Cost, 0);
    run_engine(10'd376, 4'd3);
    chk("idle_sum_hold", table_sum, 2016);
    W = 3'd5;
    J = 3'd3;
    #1;
    chk("idle_cost_zero", Cost, 0);

    // Reset mid-LOAD, with jam_valid asserted during LOAD.
    for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(0, 127));
    jam_valid   = 1'b1;
    jam_mincost = 10'd999;
    load_words(20, 1'b0, 1'b0);
    jam_valid = 1'b0;
    chk("load_jam_res_valid", res_valid, 0);
    chk("load_jam_mincost", res_mincost, 376);
    RST      = 1'b0;
    in_valid = 1'b1;
    tick();
    RST      = 1'b1;
    in_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", table_sum, 0);
    chk("midrst_mincost", res_mincost, 10'h3FF);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 64; i++) tbl[i] = 7'd127;
    load_words(64, 1'b0, 1'b1);
    chk("sum_8128", table_sum, 8128);
    read_back();
    run_engine(10'd100, 4'd5);

    // Back-to-back runs with distinct tables.
    for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(0, 127));
    load_words(64, 1'b1, 1'b1);
    read_back();
    run_engine(10'd513, 4'd9);
    for (int i = 0; i < 64; i++) tbl[i] = 7'((i * 37 + 11) % 128);
    load_words(64, 1'b0, 1'b1);
    chk("b2b_res_before", res_mincost, last_mc);
    read_back();
    run_engine(10'd42, 4'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cost_table_ctrl.md
COST_TABLE_CTRL -- requirements
Module: cost_table_ctrl

Interface
REQ-001 Parameter COST_W, default 7, is the width of one cost entry and of `in_data` and `Cost`.
REQ-002 `CLK` input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 `RST` input, 1 bit: synchronous, active-low reset.
REQ-004 `in_valid` input, 1 bit: the loader presents a cost word.
REQ-005 `in_data` input, COST_W bits: cost word, row-major order (worker 0 jobs 0..7, then worker 1, ...).
REQ-006 `in_ready` output, 1 bit: the block accepts `in_data` this cycle.
REQ-007 `W` input, 3 bits: worker index, from the assignment engine.
REQ-008 `J` input, 3 bits: job index, from the assignment engine.
REQ-009 `Cost` output, COST_W bits: cost entry for (`W`,`J`).
REQ-010 `jam_rst` output, 1 bit: active-high hold-reset to the assignment engine.
REQ-011 `jam_valid` input, 1 bit: the assignment engine reports that its search is finished.
REQ-012 `jam_mincost` input, 10 bits: engine minimum cost.
REQ-013 `jam_matchcount` input, 4 bits: engine match count.
REQ-014 `res_valid` output, 1 bit: one-cycle result strobe.
REQ-015 `res_mincost` output, 10 bits: captured minimum cost.
REQ-016 `res_matchcount` output, 4 bits: captured match count.
REQ-017 `table_sum` output, COST_W+6 bits: sum of all 64 loaded entries.
REQ-018 `busy` output, 1 bit: high in the LOAD and RUN states.

Function
REQ-019 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-020 A word is accepted only when `in_valid` and `in_ready` are both 1 on a rising edge.
REQ-021 `in_ready` SHALL be 1 in IDLE and LOAD, and 0 in RUN and DONE.
REQ-022 Storage: 64 x COST_W registers, addressed by a 6-bit write index `widx`.
  - Each accepted word is written to mem[widx].
  - `widx` increments by 1 on each acceptance.
REQ-023 IDLE -> LOAD on the first acceptance, which writes mem[0].
REQ-024 LOAD -> RUN on the acceptance with `widx`==63.
  - `widx` wraps to 0 at that point.
  - No 65th word can be accepted.
REQ-025 `table_sum` SHALL accumulate every accepted word, zero-extended, with no overflow possible (64 x 127 = 8128 < 2^13).
REQ-026 `table_sum` is cleared on the IDLE -> LOAD transition, so the first word becomes the new sum.
REQ-027 `table_sum` holds its value in RUN, DONE and IDLE.
REQ-028 `Cost` SHALL be a combinational read of mem[{`W`,`J`}] in RUN, giving zero-latency response in the same cycle.
REQ-029 `Cost` SHALL be 0 in IDLE, LOAD and DONE.
REQ-030 `jam_rst` SHALL be 1 in IDLE, LOAD and DONE, and 0 in RUN.
  - The engine therefore restarts cleanly on every run.
  - `jam_rst` first reads 0 the cycle after the 64th acceptance.
REQ-031 In RUN, `jam_valid`==1 SHALL capture `jam_mincost` into `res_mincost` and `jam_matchcount` into `res_matchcount`, and move to DONE.
REQ-032 `jam_valid` is ignored outside RUN.
REQ-033 DONE lasts exactly one cycle with `res_valid`==1, then goes to IDLE; `res_valid` is 0 in all other states.
REQ-034 `res_mincost` and `res_matchcount` hold until the next capture.
REQ-035 `in_valid`==1 during DONE is not accepted (`in_ready`=0); the word must be re-presented in IDLE.
REQ-036 Memory contents persist across runs; a new load fully overwrites them.
REQ-037 `busy` SHALL be 1 in LOAD and RUN, and 0 otherwise.

Reset
REQ-038 On a rising edge with `RST`==0, the block SHALL:
  - go to state IDLE;
  - set `widx`=0 and `table_sum`=0;
  - set `res_valid`=0, `res_mincost`=10'h3FF and `res_matchcount`=0;
  - which makes `in_ready`=1, `jam_rst`=1, `busy`=0 and `Cost`=0.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation; the next load restarts at mem[0].
REQ-041 Reset has priority over every other event in the same cycle.

Verification
REQ-042 Full load, stalls, and read-back:
  - Stimulus: load 64 words with value = (index mod 128), with `in_valid` deasserted every 3rd cycle.
  - Response: `table_sum`=2016, and the FSM enters RUN exactly after the 64th acceptance.
  - Then drive `W`=5, `J`=3: `Cost`=43 in the same cycle.
REQ-043 Engine handshake:
  - Stimulus: in RUN, pulse `jam_valid` with `jam_mincost`=10'd376 and `jam_matchcount`=4'd3.
  - Response: the next cycle shows `res_valid`=1 for exactly one cycle with 376/3, `jam_rst`=1, then IDLE with `in_ready`=1.
REQ-044 Illegal-state inputs:
  - Stimulus: `in_valid` held at 1 through RUN and DONE.
  - Response: no writes; `widx` stays 0 and `table_sum` is unchanged.
  - Stimulus: `jam_valid` asserted in IDLE or LOAD.
  - Response: no capture and no `res_valid`.
REQ-045 Reset mid-LOAD:
  - Stimulus: assert `RST`=0 after 20 accepted words, then reload 64 words of all 127.
  - Response: `table_sum`=8128, and `Cost`=127 for every (`W`,`J`).
REQ-046 Back-to-back runs:
  - Stimulus: two complete load/run cycles with different tables.
  - Response: the second `table_sum` reflects only the second table, and results update on the second `res_valid`.
